// File: rtl/dct_pass_sched_if.sv
// Handshake bundle between the row/column pass scheduler and its environment
// (command source, source buffers, 1-D transform datapath, destination buffer).
// The stall_cnt_o signal exists only when DCT_SCHED_PERF_EN is defined.
interface dct_pass_sched_if;
  logic       start_i;
  logic [1:0] size_i;
  logic       busy_o;
  logic       done_o;
  logic       src_rd_o;
  logic [4:0] src_addr_o;
  logic       pass_o;
  logic       dst_rdy_i;
  logic       dp_vld_o;
  logic [1:0] dp_size_o;
  logic       dp_vld_i;
  logic       wr_en_o;
  logic [4:0] wr_addr_o;
`ifdef DCT_SCHED_PERF_EN
  logic [15:0] stall_cnt_o;

  // scheduler side
  modport master (
    input  start_i, size_i, dst_rdy_i, dp_vld_i,
    output busy_o, done_o, src_rd_o, src_addr_o, pass_o,
    output dp_vld_o, dp_size_o, wr_en_o, wr_addr_o, stall_cnt_o
  );

  // environment side
  modport slave (
    output start_i, size_i, dst_rdy_i, dp_vld_i,
    input  busy_o, done_o, src_rd_o, src_addr_o, pass_o,
    input  dp_vld_o, dp_size_o, wr_en_o, wr_addr_o, stall_cnt_o
  );
`else
  // scheduler side
  modport master (
    input  start_i, size_i, dst_rdy_i, dp_vld_i,
    output busy_o, done_o, src_rd_o, src_addr_o, pass_o,
    output dp_vld_o, dp_size_o, wr_en_o, wr_addr_o
  );

  // environment side
  modport slave (
    output start_i, size_i, dst_rdy_i, dp_vld_i,
    input  busy_o, done_o, src_rd_o, src_addr_o, pass_o,
    input  dp_vld_o, dp_size_o, wr_en_o, wr_addr_o
  );
`endif
endinterface

// File: rtl/dct_pass_sched.sv
// Row/column pass scheduler for the 2-D forward transform. One TU command
// (4x4..32x32) is run through the 32-lane 1-D datapath twice: a row pass
// into the transpose buffer, then a column pass into the output buffer.
// Optional stall-cycle counter enabled by defining DCT_SCHED_PERF_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_i; counters held clear
// S_ISSUE0 | row pass: one source read per cycle with dst_rdy_i
// S_DRAIN0 | row pass: waiting for the remaining datapath writes
// S_ISSUE1 | column pass: reads from the transpose buffer
// S_DRAIN1 | column pass: waiting for writes, done_o on the last one
module dct_pass_sched #(
  parameter int DP_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dct_pass_sched_if.master  bus
);

  // In-flight count never exceeds DP_LAT; a little headroom keeps it simple.
  localparam int IFW = $clog2(DP_LAT + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_DRAIN0,
    S_ISSUE1,
    S_DRAIN1
  } state_t;

  state_t           state;
  logic [5:0]       iss_cnt;
  logic [5:0]       wr_cnt;
  logic [IFW-1:0]   inflight;
  logic [1:0]       size_q;
  logic             busy_q;
  logic             done_q;
  logic             dp_vld_q;
  logic             pass_q;

  logic [5:0]       beats;
  logic [5:0]       last_beat;
  logic [4:0]       addr_mask;
  logic             in_issue;
  logic             issue;
  logic             wr_evt;
  logic             start_acc;

  // Beats per pass for the latched size; the mask keeps addresses below B.
  always_comb begin
    beats     = 6'd1;
    addr_mask = 5'd0;
    case (size_q)
      2'd0: begin beats = 6'd1;  addr_mask = 5'd0;  end
      2'd1: begin beats = 6'd2;  addr_mask = 5'd1;  end
      2'd2: begin beats = 6'd8;  addr_mask = 5'd7;  end
      default: begin beats = 6'd32; addr_mask = 5'd31; end
    endcase
  end

  assign last_beat = beats - 6'd1;
  assign in_issue  = (state == S_ISSUE0) || (state == S_ISSUE1);
  assign issue     = in_issue && bus.dst_rdy_i;
  assign wr_evt    = bus.dp_vld_i && (state != S_IDLE);
  assign start_acc = bus.start_i && !busy_q;

  // Pass sequencing, beat counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      iss_cnt  <= '0;
      wr_cnt   <= '0;
      inflight <= '0;
      size_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dp_vld_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dp_vld_q <= issue;
      if (wr_evt) wr_cnt <= wr_cnt + 6'd1;
      inflight <= inflight + IFW'(dp_vld_q) - IFW'(wr_evt && (inflight != '0));
      case (state)
        S_IDLE: begin
          iss_cnt  <= '0;
          wr_cnt   <= '0;
          inflight <= '0;
          pass_q   <= 1'b0;
          // busy stays up through the done_o cycle, so a start there is dropped
          busy_q   <= start_acc;
          if (start_acc) begin
            size_q <= bus.size_i;
            state  <= S_ISSUE0;
          end
        end
        S_ISSUE0, S_ISSUE1: begin
          if (issue) begin
            if (iss_cnt == last_beat)
              state <= (state == S_ISSUE0) ? S_DRAIN0 : S_DRAIN1;
            else
              iss_cnt <= iss_cnt + 6'd1;
          end
        end
        S_DRAIN0: begin
          // column pass reads the transpose buffer only once it is fully written
          if ((wr_cnt == beats) && (inflight == '0)) begin
            state    <= S_ISSUE1;
            pass_q   <= 1'b1;
            iss_cnt  <= '0;
            wr_cnt   <= '0;
            inflight <= '0;
          end
        end
        S_DRAIN1: begin
          if (wr_evt && (wr_cnt == last_beat)) begin
            done_q <= 1'b1;
            pass_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCT_SCHED_PERF_EN
  logic [15:0] stall_q;

  // Counts issue cycles blocked by the destination, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (start_acc)
      stall_q <= '0;
    else if (in_issue && !bus.dst_rdy_i && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign bus.stall_cnt_o = stall_q;
`endif

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.src_rd_o   = issue;
  assign bus.src_addr_o = iss_cnt[4:0] & addr_mask;
  assign bus.pass_o     = pass_q;
  assign bus.dp_vld_o   = dp_vld_q;
  assign bus.dp_size_o  = size_q;
  assign bus.wr_en_o    = bus.dp_vld_i;
  assign bus.wr_addr_o  = wr_cnt[4:0] & addr_mask;

endmodule

// File: doc/dct_pass_sched.md
# dct_pass_sched

Pass scheduler for the 2-D forward-transform datapath in `rec_tq`. It accepts one TU command (size 4x4 to 32x32) and sequences beats through the 1-D datapath twice: a row pass, then a column pass. The datapath is the butterfly plus output-reorder stage plus multiplier tree, 32 lanes wide.
- For each pass it:
  - issues source-buffer reads;
  - drives the datapath valid and the datapath size select;
  - tracks beats in flight;
  - generates transpose/output write addresses;
  - reports completion.

## Interface
- `DP_LAT`, 4: cycles from `dp_vld_o` to the matching `dp_vld_i` at the datapath output. Legal range 1..15.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start_i` input 1: command strobe; honoured only while `busy_o`=0.
- `size_i` input 2: TU size (0=4x4, 1=8x8, 2=16x16, 3=32x32); sampled on an accepted `start_i`.
- `busy_o` output 1: high from the cycle after an accepted start until the cycle of `done_o`.
- `done_o` output 1: one-cycle pulse on the last column-pass write.
- `src_rd_o` output 1: source read strobe (residual buffer in pass 0, transpose buffer in pass 1).
- `src_addr_o` output 5: beat index of the read.
- `pass_o` output 1: 0 = row pass, 1 = column pass.
- `dst_rdy_i` input 1: destination can accept; gates issue of new reads.
- `dp_vld_o` output 1: datapath input valid; equals `src_rd_o` delayed one cycle (buffer read latency).
- `dp_size_o` output 2: datapath size select; the latched size, stable for the whole command.
- `dp_vld_i` input 1: datapath output valid.
- `wr_en_o` output 1: destination write enable; equals `dp_vld_i` (combinational).
- `wr_addr_o` output 5: destination beat index.
- `stall_cnt_o` output 16: stall-cycle counter; present only with `DCT_SCHED_PERF_EN`.

## Operation
- Beats per pass, B: 1 / 2 / 8 / 32 for size 0 / 1 / 2 / 3. Each beat carries 32 samples; a 4x4 TU uses lanes 0..15 only.
- FSM states: IDLE, ISSUE0, DRAIN0, ISSUE1, DRAIN1.
- IDLE:
  - `start_i` latches `size_i` and goes to ISSUE0.
  - Issue counter, write counter and in-flight counter clear.
- ISSUE0 / ISSUE1:
  - Each cycle with `dst_rdy_i`=1: assert `src_rd_o` with `src_addr_o` = issue count, then increment the issue count.
  - A cycle with `dst_rdy_i`=0 issues nothing.
  - After issue B-1, go to DRAIN0 / DRAIN1.
- DRAIN0:
  - Each `dp_vld_i` increments the write count.
  - When the write count reaches B, go to ISSUE1 and clear both counters.
  - Pass 1 never reads before every pass-0 write has completed.
- DRAIN1: same as DRAIN0, but on the final write pulse `done_o` and return to IDLE.
- Writes arriving during ISSUEx are counted in that pass; `wr_addr_o` = write count, `pass_o` = current pass.
- Skid requirement on the destination: after it drops `dst_rdy_i`, it absorbs up to DP_LAT+1 further writes. The scheduler does not throttle `dp_vld_i`.
- Error handling:
  - `start_i` while busy is ignored.
  - `dp_vld_i` in IDLE is ignored: no write count, but `wr_en_o` still follows it.

## Timing
- Reset values: state IDLE; every output 0, including `dp_size_o`, `stall_cnt_o` and all counters.
- Reset asserted mid-command aborts immediately. In-flight datapath beats are not tracked after reset.
- Start in cycle t: `src_rd_o` no earlier than t+1; `dp_vld_o` at t+2.
- Latency with `dst_rdy_i` held high, start to `done_o`: 2·(B+DP_LAT+1)+2 cycles. For a 4x4 TU with DP_LAT=4 this is 14.
- Back-to-back commands: a `start_i` in the same cycle as `done_o` is not accepted (busy still 1). The earliest accepted start is the cycle after `done_o`.
- Address wrap: counters are 6 bits internally, so 32 is reachable; `*_addr_o` is the low 5 bits and never exceeds B-1.

## Configuration
- `DCT_SCHED_PERF_EN` defined:
  - `stall_cnt_o` increments in ISSUE0/ISSUE1 cycles with `dst_rdy_i`=0.
  - Saturates at 16'hFFFF.
  - Clears on accepted `start_i`.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Size 0, DP_LAT=4, `dst_rdy_i`=1, datapath modelled as a 4-cycle delay: start at t=0 → one read per pass; `done_o` at t=14; `busy_o` high t=1..14.
- Size 3, no stall → `src_addr_o` 0..31 per pass; writes 0..31 in pass 0 then 0..31 in pass 1; no pass-1 read before the 32nd pass-0 write.
- Size 2, drop `dst_rdy_i` for 5 cycles after the 3rd issue → issue resumes at addr 3; with PERF `stall_cnt_o`=5; `done_o` delayed by exactly 5 cycles.
- `start_i` pulsed mid-command with size 0 during a size-3 command → ignored; `dp_size_o` stays 3; a single `done_o`.
- `rst_n` low during DRAIN1 of size 1 → all outputs 0 asynchronously; a new size-1 start after release completes normally.
- Back-to-back: second start in the `done_o` cycle → ignored; start one cycle later → accepted.
